// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, field widths and unit timings for the Morse keyer.
package morse_pkg;
    typedef enum logic [2:0] {IDLE, ALIGN, MARK, EGAP, CGAP} state_t;
    localparam int CODE_W = 6;
    localparam int PAT_W  = 5;
    localparam int LEN_W  = 3;
    localparam logic [1:0] DOT_UNITS  = 2'd1;
    localparam logic [1:0] DASH_UNITS = 2'd3;
    localparam logic [1:0] ELEM_GAP   = 2'd1;
    localparam logic [1:0] CHAR_GAP   = 2'd3;
    localparam logic [CODE_W-1:0] CODE_A      = 6'd0;
    localparam logic [CODE_W-1:0] CODE_DIGIT0 = 6'd26;
    function automatic logic [1:0] elem_units(input logic dash);
        return dash ? DASH_UNITS : DOT_UNITS;
    endfunction
endpackage

// File: rtl/morse_rom.sv
// morse_rom: character code to {len, pattern} lookup, pattern bit 0 is the first element, 1 = dash.
// Digits 0..9 on codes 26..35 are included only when MORSE_DIGITS_EN is defined.
module morse_rom
    import morse_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [LEN_W-1:0]  len,
    output logic [PAT_W-1:0]  pattern
);
    always_comb begin
        {len, pattern} = '0;
        case (code)
            CODE_A: {len, pattern} = {3'd2, 5'b00010};
            6'd1:   {len, pattern} = {3'd4, 5'b00001};
            6'd2:   {len, pattern} = {3'd4, 5'b00101};
            6'd3:   {len, pattern} = {3'd3, 5'b00001};
            6'd4:   {len, pattern} = {3'd1, 5'b00000};
            6'd5:   {len, pattern} = {3'd4, 5'b00100};
            6'd6:   {len, pattern} = {3'd3, 5'b00011};
            6'd7:   {len, pattern} = {3'd4, 5'b00000};
            6'd8:   {len, pattern} = {3'd2, 5'b00000};
            6'd9:   {len, pattern} = {3'd4, 5'b01110};
            6'd10:  {len, pattern} = {3'd3, 5'b00101};
            6'd11:  {len, pattern} = {3'd4, 5'b00010};
            6'd12:  {len, pattern} = {3'd2, 5'b00011};
            6'd13:  {len, pattern} = {3'd2, 5'b00001};
            6'd14:  {len, pattern} = {3'd3, 5'b00111};
            6'd15:  {len, pattern} = {3'd4, 5'b00110};
            6'd16:  {len, pattern} = {3'd4, 5'b01011};
            6'd17:  {len, pattern} = {3'd3, 5'b00010};
            6'd18:  {len, pattern} = {3'd3, 5'b00000};
            6'd19:  {len, pattern} = {3'd1, 5'b00001};
            6'd20:  {len, pattern} = {3'd3, 5'b00100};
            6'd21:  {len, pattern} = {3'd4, 5'b01000};
            6'd22:  {len, pattern} = {3'd3, 5'b00110};
            6'd23:  {len, pattern} = {3'd4, 5'b01001};
            6'd24:  {len, pattern} = {3'd4, 5'b01101};
            6'd25:  {len, pattern} = {3'd4, 5'b00011};
`ifdef MORSE_DIGITS_EN
            CODE_DIGIT0:         {len, pattern} = {3'd5, 5'b11111};
            CODE_DIGIT0 + 6'd1:  {len, pattern} = {3'd5, 5'b11110};
            CODE_DIGIT0 + 6'd2:  {len, pattern} = {3'd5, 5'b11100};
            CODE_DIGIT0 + 6'd3:  {len, pattern} = {3'd5, 5'b11000};
            CODE_DIGIT0 + 6'd4:  {len, pattern} = {3'd5, 5'b10000};
            CODE_DIGIT0 + 6'd5:  {len, pattern} = {3'd5, 5'b00000};
            CODE_DIGIT0 + 6'd6:  {len, pattern} = {3'd5, 5'b00001};
            CODE_DIGIT0 + 6'd7:  {len, pattern} = {3'd5, 5'b00011};
            CODE_DIGIT0 + 6'd8:  {len, pattern} = {3'd5, 5'b00111};
            CODE_DIGIT0 + 6'd9:  {len, pattern} = {3'd5, 5'b01111};
`endif
            default: {len, pattern} = '0;
        endcase
    end
endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: keys one character at a time, all mark/space edges aligned to unit_tick.
// Digit support comes from morse_rom under MORSE_DIGITS_EN.
module morse_keyer
    import morse_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              unit_tick,
    input  logic              char_valid,
    input  logic [CODE_W-1:0] char_code,
    output logic              char_ready,
    output logic              key_out,
    output logic              busy
);
    state_t            state;
    logic [PAT_W-1:0]  pat, rom_pat;
    logic [LEN_W-1:0]  len, rom_len, idx;
    logic [1:0]        cnt;

    morse_rom u_rom (.code(char_code), .len(rom_len), .pattern(rom_pat));

    assign char_ready = state == IDLE;
    assign busy       = state != IDLE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            pat     <= '0;
            len     <= '0;
            idx     <= '0;
            cnt     <= '0;
            key_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (char_valid) begin
                    pat   <= rom_pat;
                    len   <= rom_len;
                    idx   <= '0;
                    state <= ALIGN;
                end
                ALIGN: if (unit_tick) begin
                    if (len == '0) begin
                        state <= CGAP;
                        cnt   <= CHAR_GAP;
                    end else begin
                        key_out <= 1'b1;
                        state   <= MARK;
                        cnt     <= elem_units(pat[0]);
                    end
                end
                MARK: if (unit_tick) begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        key_out <= 1'b0;
                        if (idx == len - 3'd1) begin
                            state <= CGAP;
                            cnt   <= CHAR_GAP;
                        end else begin
                            state <= EGAP;
                            cnt   <= ELEM_GAP;
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                // idx already points at the next element here
                EGAP: if (unit_tick) begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        key_out <= 1'b1;
                        state   <= MARK;
                        cnt     <= elem_units(pat[idx]);
                    end
                end
                CGAP: if (unit_tick) begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: table vectors, hand sequences and random characters checked against a unit-level Morse model.
module tb_morse_keyer;
    typedef bit bq_t[$];
    typedef struct {
        logic [5:0] code;
        string      units;
        bit         coinc;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       unit_tick = 1'b0;
    logic       char_valid = 1'b0;
    logic [5:0] char_code = '0;
    logic       char_ready, key_out, busy;
    int         checks = 0;
    int         errors = 0;
    int         accepts = 0;
    vec_t       vecs[9];
    string      ref_tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                                ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                                "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                                "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                                "--...", "---..", "----."};

    morse_keyer dut (.CLK(CLK), .RST_N(RST_N), .unit_tick(unit_tick), .char_valid(char_valid),
                     .char_code(char_code), .char_ready(char_ready), .key_out(key_out), .busy(busy));

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (char_valid && char_ready) accepts <= accepts + 1;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "1");
        return q;
    endfunction

    // key level per unit after alignment: marks of 1/3 units, 1-unit gaps, 3-unit tail
    function automatic bq_t model(input int code);
        bq_t q;
        string m = "";
        if (code < 26) m = ref_tab[code];
`ifdef MORSE_DIGITS_EN
        else if (code < 36) m = ref_tab[code];
`endif
        if (m.len() == 0) begin
            repeat (3) q.push_back(1'b0);
            return q;
        end
        for (int i = 0; i < m.len(); i++) begin
            repeat ((m[i] == "-") ? 3 : 1) q.push_back(1'b1);
            repeat ((i == m.len() - 1) ? 3 : 1) q.push_back(1'b0);
        end
        return q;
    endfunction

    task automatic run_char(input logic [5:0] code, input bq_t exp, input bit coinc,
                            input int gap, input string nm);
        check({nm, " ready_before"}, char_ready, 1);
        char_valid = 1'b1;
        char_code  = code;
        unit_tick  = coinc;
        @(posedge CLK); #1;
        char_valid = 1'b0;
        unit_tick  = 1'b0;
        check({nm, " busy_after_accept"}, busy, 1);
        check({nm, " key_after_accept"}, key_out, 0);
        for (int u = 0; u <= exp.size(); u++) begin
            repeat (gap > 0 ? gap : $urandom_range(1, 4)) begin
                @(posedge CLK); #1;
                check({nm, " key_hold"}, key_out, (u == 0) ? 1'b0 : exp[u-1]);
            end
            unit_tick = 1'b1;
            @(posedge CLK); #1;
            unit_tick = 1'b0;
            if (u < exp.size()) begin
                check({nm, " key_unit"}, key_out, exp[u]);
                check({nm, " busy_unit"}, busy, 1);
            end else begin
                check({nm, " ready_end"}, char_ready, 1);
                check({nm, " busy_end"}, busy, 0);
                check({nm, " key_end"}, key_out, 0);
            end
        end
    endtask

    initial begin
        bq_t got, want;
        vecs = '{'{6'd4,  "1000",           1'b0},
                 '{6'd0,  "10111000",       1'b0},
                 '{6'd19, "111000",         1'b0},
                 '{6'd18, "10101000",       1'b0},
                 '{6'd14, "11101110111000", 1'b0},
                 '{6'd4,  "1000",           1'b1},
                 '{6'd13, "11101000",       1'b1},
                 '{6'd40, "000",            1'b0},
                 '{6'd63, "000",            1'b0}};
        repeat (3) @(posedge CLK);
        #1;
        check("reset key", key_out, 0);
        check("reset ready", char_ready, 1);
        check("reset busy", busy, 0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        check("idle ready", char_ready, 1);

        run_char(6'd4, str2q("1000"), 1'b0, 9, "E_10clk");

        foreach (vecs[i]) run_char(vecs[i].code, str2q(vecs[i].units), vecs[i].coinc, 0, "vec");

`ifdef MORSE_DIGITS_EN
        run_char(6'd26, str2q("1110111011101110111000"), 1'b0, 0, "digit0");
`else
        run_char(6'd26, str2q("000"), 1'b0, 0, "code26");
`endif

        // back-to-back T with char_valid held: second accept lands in the single IDLE cycle
        accepts    = 0;
        char_code  = 6'd19;
        char_valid = 1'b1;
        for (int t = 0; t < 14; t++) begin
            repeat (2) @(posedge CLK);
            #1;
            unit_tick = 1'b1;
            @(posedge CLK); #1;
            unit_tick = 1'b0;
            got.push_back(key_out);
        end
        char_valid = 1'b0;
        want = str2q("11100001110000");
        foreach (want[i]) check("TT key_unit", got[i], want[i]);
        repeat (3) @(posedge CLK);
        #1;
        check("TT accepts", accepts, 2);
        check("TT ready", char_ready, 1);

        // reset during the leading dash of N
        char_valid = 1'b1;
        char_code  = 6'd13;
        @(posedge CLK); #1;
        char_valid = 1'b0;
        for (int t = 0; t < 2; t++) begin
            repeat (2) @(posedge CLK);
            #1;
            unit_tick = 1'b1;
            @(posedge CLK); #1;
            unit_tick = 1'b0;
        end
        check("N key_before_reset", key_out, 1);
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        check("N async key", key_out, 0);
        check("N async ready", char_ready, 1);
        check("N async busy", busy, 0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        run_char(6'd4, str2q("1000"), 1'b0, 0, "E_after_reset");

        for (int i = 0; i < 20; i++) begin
            logic [5:0] c;
            c = 6'($urandom_range(0, 63));
            run_char(c, model(c), 1'($urandom_range(0, 1)), 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
